// File: rtl/seg7_decoder.sv
// Hex nibble to seven-segment decoder with a combinational output and a
// registered output; both share one decode and one polarity stage.
module seg7_decoder #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] iv_digit,
    input  logic       i_blank,
    output logic [6:0] ov_seg_async,
    output logic [6:0] ov_seg_sync
);

    // XOR mask applied after decode; also the "all segments off" value.
    localparam logic [6:0] POL_MASK = ACTIVE_LOW ? 7'h7F : 7'h00;

    // Active-high glyphs, bit0=a .. bit6=g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        seg = 7'h00;
        case (digit)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [6:0] seg_hi_s;
    logic [6:0] seg_sync_r;

    // Shared decode; blank overrides the digit before polarity is applied.
    always_comb begin
        seg_hi_s = 7'h00;
        if (i_blank) begin
            seg_hi_s = 7'h00;
        end else begin
            seg_hi_s = hex_to_seg(iv_digit);
        end
    end

    assign ov_seg_async = seg_hi_s ^ POL_MASK;

    // Output register: reset shows a dark digit in either polarity.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seg_sync_r <= POL_MASK;
        end else begin
            seg_sync_r <= ov_seg_async;
        end
    end

    assign ov_seg_sync = seg_sync_r;

endmodule

// File: tb/tb_seg7_decoder.sv
// Randomized self-checking bench for seg7_decoder; drives a common-cathode and
// a common-anode instance in parallel against a segment-list reference model.
module tb_seg7_decoder;

    logic       clk;
    logic       rst_n;
    logic [3:0] digit;
    logic       blank;
    logic [6:0] async_hi, sync_hi, async_lo, sync_lo;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Lit segments per glyph, named by the standard a..g layout.
    string shapes [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                           "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                           "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    seg7_decoder #(.ACTIVE_LOW(1'b0)) dut_hi (
        .i_clk(clk), .i_rst_n(rst_n), .iv_digit(digit), .i_blank(blank),
        .ov_seg_async(async_hi), .ov_seg_sync(sync_hi)
    );

    seg7_decoder #(.ACTIVE_LOW(1'b1)) dut_lo (
        .i_clk(clk), .i_rst_n(rst_n), .iv_digit(digit), .i_blank(blank),
        .ov_seg_async(async_lo), .ov_seg_sync(sync_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model(input int d, input bit blk, input bit al);
        logic [6:0] seg;
        string s;
        seg = 7'h00;
        s = shapes[d];
        if (!blk)
            for (int i = 0; i < s.len(); i++) seg[s[i] - "a"] = 1'b1;
        return al ? ~seg : seg;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; digit = 4'h8; blank = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (sync_hi !== 7'h00) $display("FAIL reset_sync_hi got %h exp 00", sync_hi); else pass_cnt++;
        chk_cnt++; if (sync_lo !== 7'h7F) $display("FAIL reset_sync_lo got %h exp 7F", sync_lo); else pass_cnt++;
        chk_cnt++; if (async_hi !== 7'h7F) $display("FAIL reset_async_hi got %h exp 7F", async_hi); else pass_cnt++;
        chk_cnt++; if (async_lo !== 7'h00) $display("FAIL reset_async_lo got %h exp 00", async_lo); else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++; if (sync_hi !== 7'h7F) $display("FAIL release_sync_hi got %h exp 7F", sync_hi); else pass_cnt++;
        chk_cnt++; if (sync_lo !== 7'h00) $display("FAIL release_sync_lo got %h exp 00", sync_lo); else pass_cnt++;
    endtask

    task automatic test_sweep();
        for (int d = 0; d < 16; d++) begin
            @(negedge clk);
            digit = d[3:0]; blank = 1'b0;
            #1;
            chk_cnt++; if (async_hi !== model(d, 1'b0, 1'b0)) $display("FAIL sweep_async_hi d=%0d got %h exp %h", d, async_hi, model(d, 1'b0, 1'b0)); else pass_cnt++;
            chk_cnt++; if (async_lo !== model(d, 1'b0, 1'b1)) $display("FAIL sweep_async_lo d=%0d got %h exp %h", d, async_lo, model(d, 1'b0, 1'b1)); else pass_cnt++;
            if (d == 0)  begin chk_cnt++; if (async_hi !== 7'h3F) $display("FAIL const_0 got %h exp 3F", async_hi); else pass_cnt++; end
            if (d == 9)  begin chk_cnt++; if (async_hi !== 7'h6F) $display("FAIL const_9 got %h exp 6F", async_hi); else pass_cnt++; end
            if (d == 15) begin chk_cnt++; if (async_hi !== 7'h71) $display("FAIL const_F got %h exp 71", async_hi); else pass_cnt++; end
            if (d == 1)  begin chk_cnt++; if (async_lo !== 7'h79) $display("FAIL const_lo_1 got %h exp 79", async_lo); else pass_cnt++; end
            @(negedge clk);
            chk_cnt++; if (sync_hi !== model(d, 1'b0, 1'b0)) $display("FAIL sweep_sync_hi d=%0d got %h exp %h", d, sync_hi, model(d, 1'b0, 1'b0)); else pass_cnt++;
            chk_cnt++; if (sync_lo !== model(d, 1'b0, 1'b1)) $display("FAIL sweep_sync_lo d=%0d got %h exp %h", d, sync_lo, model(d, 1'b0, 1'b1)); else pass_cnt++;
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        digit = 4'h1; blank = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #3;
        digit = 4'h2;
        #1;
        chk_cnt++; if (sync_hi !== 7'h06) $display("FAIL latency_before got %h exp 06", sync_hi); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (sync_hi !== 7'h5B) $display("FAIL latency_after got %h exp 5B", sync_hi); else pass_cnt++;
    endtask

    task automatic test_blank();
        @(negedge clk);
        digit = 4'h3; blank = 1'b1;
        #1;
        chk_cnt++; if (async_hi !== 7'h00) $display("FAIL blank_async_hi got %h exp 00", async_hi); else pass_cnt++;
        chk_cnt++; if (async_lo !== 7'h7F) $display("FAIL blank_async_lo got %h exp 7F", async_lo); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (sync_hi !== 7'h00) $display("FAIL blank_sync_hi got %h exp 00", sync_hi); else pass_cnt++;
        chk_cnt++; if (sync_lo !== 7'h7F) $display("FAIL blank_sync_lo got %h exp 7F", sync_lo); else pass_cnt++;
        blank = 1'b0;
        #1;
        chk_cnt++; if (async_hi !== 7'h4F) $display("FAIL unblank_async got %h exp 4F", async_hi); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (sync_hi !== 7'h4F) $display("FAIL unblank_sync got %h exp 4F", sync_hi); else pass_cnt++;
    endtask

    task automatic test_random();
        int d;
        bit b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            d = $urandom_range(15, 0);
            b = ($urandom_range(3, 0) == 0);
            digit = d[3:0]; blank = b;
            #1;
            chk_cnt++; if (async_hi !== model(d, b, 1'b0)) $display("FAIL rand_async_hi d=%0d b=%0d got %h exp %h", d, b, async_hi, model(d, b, 1'b0)); else pass_cnt++;
            chk_cnt++; if (async_lo !== model(d, b, 1'b1)) $display("FAIL rand_async_lo d=%0d b=%0d got %h exp %h", d, b, async_lo, model(d, b, 1'b1)); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (sync_hi !== model(d, b, 1'b0)) $display("FAIL rand_sync_hi d=%0d b=%0d got %h exp %h", d, b, sync_hi, model(d, b, 1'b0)); else pass_cnt++;
            chk_cnt++; if (sync_lo !== model(d, b, 1'b1)) $display("FAIL rand_sync_lo d=%0d b=%0d got %h exp %h", d, b, sync_lo, model(d, b, 1'b1)); else pass_cnt++;
        end
    endtask

    task automatic test_midrun_reset();
        @(negedge clk);
        digit = 4'h6; blank = 1'b0;
        @(posedge clk); #2;
        chk_cnt++; if (sync_hi !== 7'h7D) $display("FAIL midrun_pre got %h exp 7D", sync_hi); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (sync_hi !== 7'h00) $display("FAIL midrun_sync_hi got %h exp 00", sync_hi); else pass_cnt++;
        chk_cnt++; if (sync_lo !== 7'h7F) $display("FAIL midrun_sync_lo got %h exp 7F", sync_lo); else pass_cnt++;
        chk_cnt++; if (async_hi !== 7'h7D) $display("FAIL midrun_async got %h exp 7D", async_hi); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (sync_hi !== 7'h00) $display("FAIL midrun_hold got %h exp 00", sync_hi); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++; if (sync_hi !== 7'h7D) $display("FAIL midrun_resume got %h exp 7D", sync_hi); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; digit = 4'h0; blank = 1'b0;
        test_reset();
        test_sweep();
        test_latency();
        test_blank();
        test_random();
        test_midrun_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
